// File: rtl/register_file_18_pkg.sv
// Shared defaults and clear-sequencer state encoding for register_file_18.
package register_file_18_pkg;

    localparam int unsigned RF_DATA_W   = 18;
    localparam int unsigned RF_ADDR_W   = 4;
    localparam int unsigned RF_NUM_REGS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/register_file_18_clear_ctrl.sv
// Bulk-clear sequencer: walks every register index once, then pulses done.
module regfile_clear_ctrl
    import register_file_18_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_idx_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Leave CLEAR on the last index so the counter never starts a second pass.
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign clr_done_o = (state_q == ST_DONE);
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_idx_o  = cnt_q;

endmodule

// File: rtl/register_file_18.sv
// 2-read/1-write register file with sequenced bulk clear.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_18
    import register_file_18_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
        $error("register_file_18: NUM_REGS must equal 2**ADDR_W");
    end

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                            clr_we;
    logic [ADDR_W-1:0]               clr_idx;
    logic                            wr_acc;

    regfile_clear_ctrl #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (clr_req),
        .busy_o     (busy),
        .clr_done_o (clr_done),
        .clr_we_o   (clr_we),
        .clr_idx_o  (clr_idx)
    );

    // Host writes only land in IDLE; a write coincident with clr_req still lands.
    assign wr_acc = we && !busy;

    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_idx] = '0;
        end else if (wr_acc) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && (raddr_a == waddr)) rdata_a = wdata;
        if (wr_acc && (raddr_b == waddr)) rdata_b = wdata;
`endif
    end

endmodule

// File: tb/tb_register_file_18.sv
// Directed self-checking bench for register_file_18.
module tb_register_file_18;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          clr_req;
    logic          busy;
    logic          clr_done;

    int checks;
    int errors;

    register_file_18 #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .ADDR_W   (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] exp);
        for (int i = 0; i < NR; i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(NR - 1 - i);
            #1;
            chk($sformatf("%s_a[%0d]", tag, i), 32'(rdata_a), 32'(exp));
            chk($sformatf("%s_b[%0d]", tag, NR - 1 - i), 32'(rdata_b), 32'(exp));
        end
    endtask

    initial begin
        logic [DW-1:0] exp_byp;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = '0;
        raddr_b = '0;
        clr_req = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        check_all("rst", '0);
        rst_n = 1'b1;
        tick();

        // Write then read on both ports
        write_reg(4'd5, 18'h2ABCD);
        raddr_a = 4'd5; raddr_b = 4'd5;
        #1;
        chk("wr5_a", 32'(rdata_a), 32'h2ABCD);
        chk("wr5_b", 32'(rdata_b), 32'h2ABCD);

        // Same-cycle read of a register being written
        we = 1'b1; waddr = 4'd5; wdata = 18'h15555; raddr_a = 4'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 18'h15555;
`else
        exp_byp = 18'h2ABCD;
`endif
        chk("byp_a", 32'(rdata_a), 32'(exp_byp));
        tick();
        we = 1'b0;
        chk("post_byp_a", 32'(rdata_a), 32'h15555);

        // Fill then bulk clear
        for (int i = 0; i < NR; i++) write_reg(AW'(i), 18'h3FFFF);
        check_all("fill", 18'h3FFFF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            we      = (k == 6);
            waddr   = 4'd3;
            wdata   = 18'h3FFFF;
            clr_req = (k == 10);
            if (k == 5) begin
                raddr_a = 4'd3;
                raddr_b = 4'd4;
            end
            #1;
            chk($sformatf("clr_busy_c%0d", k), 32'(busy), 32'd1);
            chk($sformatf("clr_done_c%0d", k), 32'(clr_done), 32'(k == 17));
            if (k == 5) begin
                chk("mid_clr_r3", 32'(rdata_a), 32'd0);
                chk("mid_clr_r4", 32'(rdata_b), 32'h3FFFF);
            end
            tick();
        end
        we = 1'b0; clr_req = 1'b0;
        chk("post_clr_busy", 32'(busy), 32'd0);
        chk("post_clr_done", 32'(clr_done), 32'd0);
        check_all("clr", '0);

        // Write and clr_req on the same edge
        we = 1'b1; waddr = 4'd7; wdata = 18'h00011; clr_req = 1'b1;
        tick();
        we = 1'b0; clr_req = 1'b0;
        raddr_a = 4'd7;
        #1;
        chk("wc_r7_c1", 32'(rdata_a), 32'h00011);
        chk("wc_busy_c1", 32'(busy), 32'd1);
        repeat (7) tick();
        chk("wc_r7_c8", 32'(rdata_a), 32'h00011);
        tick();
        chk("wc_r7_c9", 32'(rdata_a), 32'd0);
        repeat (8) tick();
        chk("wc_done_c17", 32'(clr_done), 32'd1);
        tick();
        chk("wc_idle_busy", 32'(busy), 32'd0);

        // Reset mid-clear
        write_reg(4'd15, 18'h3FFFF);
        write_reg(4'd9, 18'h00ABC);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5) tick();
        chk("rc_busy_c6", 32'(busy), 32'd1);
        rst_n = 1'b0;
        raddr_a = 4'd15; raddr_b = 4'd9;
        #1;
        chk("rc_busy_async", 32'(busy), 32'd0);
        chk("rc_r15_async", 32'(rdata_a), 32'd0);
        chk("rc_r9_async", 32'(rdata_b), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy !== 1'b0 || clr_done !== 1'b0)
                chk($sformatf("rc_idle_c%0d", k), {30'd0, busy, clr_done}, 32'd0);
        end
        chk("rc_busy_idle", 32'(busy), 32'd0);
        chk("rc_done_idle", 32'(clr_done), 32'd0);
        check_all("rc", '0);
        write_reg(4'd9, 18'h12345);
        raddr_a = 4'd9; raddr_b = 4'd8;
        #1;
        chk("rc_r9_wr", 32'(rdata_a), 32'h12345);
        chk("rc_r8", 32'(rdata_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
